// File: rtl/cpu_run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_monitor_pkg
// Description : Shared status codes, FSM encoding and width helper for the
//               risc_cpu run-completion monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_run_monitor_pkg;

    typedef enum logic [2:0] {
        ST_NONE    = 3'd0,
        ST_PASS    = 3'd1,
        ST_BAD_PC  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_STALL   = 3'd4
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Cycle counter must be able to hold TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_run_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_monitor_if
// Description : Bundle between the core-side observer (master) and the run
//               monitor (slave): start/expect, core taps, verdict and trace.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_run_monitor_if #(
    parameter int PC_W  = 5,
    parameter int AC_W  = 8,
    parameter int CNT_W = 10,
    parameter int IDX_W = 3
);
    logic             start;
    logic [PC_W-1:0]  expected_pc;
    logic [PC_W-1:0]  pc_in;
    logic             halt_in;
    logic [AC_W-1:0]  ac_in;
    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  halt_pc;
    logic [AC_W-1:0]  halt_ac;
    logic [IDX_W-1:0] trace_idx;
    logic [PC_W-1:0]  trace_pc;

    modport master (
        output start, expected_pc, pc_in, halt_in, ac_in, trace_idx,
        input  busy, done, status, cycle_count, halt_pc, halt_ac, trace_pc
    );

    modport slave (
        input  start, expected_pc, pc_in, halt_in, ac_in, trace_idx,
        output busy, done, status, cycle_count, halt_pc, halt_ac, trace_pc
    );
endinterface
`default_nettype wire

// File: rtl/cpu_run_monitor_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : run_mon_trace_buf
// Description : Circular buffer of the most recent PC changes; read index 0
//               is the newest entry. Built only when RUN_MON_TRACE_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef RUN_MON_TRACE_EN
module run_mon_trace_buf #(
    parameter int PC_W  = 5,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             wr_en,
    input  wire logic [PC_W-1:0]  wr_pc,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [PC_W-1:0]  rd_pc
);
    logic [PC_W-1:0]  entries_q [DEPTH];
    logic [PC_W-1:0]  entries_d [DEPTH];
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W-1:0] wr_ptr_d;
    logic [IDX_W-1:0] w_rd_addr;

    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            wr_ptr_d = '0;
        end else if (wr_en) begin
            entries_d[wr_ptr_q] = wr_pc;
            wr_ptr_d            = wr_ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Modulo-DEPTH wrap comes for free from the IDX_W-bit subtraction.
    assign w_rd_addr = wr_ptr_q - IDX_W'(1) - rd_idx;
    assign rd_pc     = entries_q[w_rd_addr];

endmodule
`endif
`default_nettype wire

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cpu_run_monitor
// Description : Cycle-accurate run-completion monitor for risc_cpu: PASS,
//               BAD_PC, TIMEOUT or STALL verdict plus captured PC/AC.
//               Optional PC trace buffer enabled by macro RUN_MON_TRACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int PC_W        = 5,
    parameter int AC_W        = 8,
    parameter int TIMEOUT     = 1000,
    parameter int STALL_LIMIT = 64,
    parameter int TRACE_DEPTH = 8
) (
    input wire logic         clk,
    input wire logic         rst,
    cpu_run_monitor_if.slave mon
);
    localparam int CNT_W   = cnt_width(TIMEOUT);
    localparam int STALL_W = $clog2(STALL_LIMIT);

    localparam logic [CNT_W-1:0]   C_CYC_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0] C_STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    state_t             state_q,     state_d;
    status_t            status_q,    status_d;
    logic [PC_W-1:0]    exp_pc_q,    exp_pc_d;
    logic [PC_W-1:0]    prev_pc_q,   prev_pc_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]    halt_pc_q,   halt_pc_d;
    logic [AC_W-1:0]    halt_ac_q,   halt_ac_d;

    logic w_pc_changed;
    assign w_pc_changed = (mon.pc_in != prev_pc_q);

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        exp_pc_d    = exp_pc_q;
        prev_pc_d   = prev_pc_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        halt_pc_d   = halt_pc_q;
        halt_ac_d   = halt_ac_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (mon.start) begin
                    state_d     = S_RUN;
                    status_d    = ST_NONE;
                    exp_pc_d    = mon.expected_pc;
                    prev_pc_d   = mon.pc_in;
                    cycle_cnt_d = '0;
                    stall_cnt_d = '0;
                end
            end
            S_RUN: begin
                // Halt outranks timeout and stall so a program that halts on
                // its last allowed cycle still gets a PC-based verdict.
                if (mon.halt_in) begin
                    state_d   = S_DONE;
                    status_d  = (mon.pc_in == exp_pc_q) ? ST_PASS : ST_BAD_PC;
                    halt_pc_d = mon.pc_in;
                    halt_ac_d = mon.ac_in;
                end else if (cycle_cnt_q == C_CYC_LAST) begin
                    state_d   = S_DONE;
                    status_d  = ST_TIMEOUT;
                    halt_pc_d = mon.pc_in;
                    halt_ac_d = mon.ac_in;
                end else if ((stall_cnt_q == C_STALL_LAST) && !w_pc_changed) begin
                    state_d   = S_DONE;
                    status_d  = ST_STALL;
                    halt_pc_d = mon.pc_in;
                    halt_ac_d = mon.ac_in;
                end else begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    stall_cnt_d = w_pc_changed ? '0 : stall_cnt_q + STALL_W'(1);
                    prev_pc_d   = mon.pc_in;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= ST_NONE;
            exp_pc_q    <= '0;
            prev_pc_q   <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            halt_pc_q   <= '0;
            halt_ac_q   <= '0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            exp_pc_q    <= exp_pc_d;
            prev_pc_q   <= prev_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            halt_pc_q   <= halt_pc_d;
            halt_ac_q   <= halt_ac_d;
        end
    end

    assign mon.busy        = (state_q == S_RUN);
    assign mon.done        = (state_q == S_DONE);
    assign mon.status      = status_q;
    assign mon.cycle_count = cycle_cnt_q;
    assign mon.halt_pc     = halt_pc_q;
    assign mon.halt_ac     = halt_ac_q;

`ifdef RUN_MON_TRACE_EN
    logic w_trace_wr;
    logic w_trace_clr;

    assign w_trace_wr  = (state_q == S_RUN) && w_pc_changed;
    assign w_trace_clr = mon.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    run_mon_trace_buf #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_trace_clr),
        .wr_en  (w_trace_wr),
        .wr_pc  (mon.pc_in),
        .rd_idx (mon.trace_idx),
        .rd_pc  (mon.trace_pc)
    );
`else
    logic w_unused_trace_idx;
    assign w_unused_trace_idx = ^mon.trace_idx;
    assign mon.trace_pc       = '0;
`endif

endmodule
`default_nettype wire
